overlay_pixel_fetch: RTL and testbench



---
 rtl/overlay_pkg.sv | 30 +++
 rtl/overlay_fifo.sv | 51 +++++
 rtl/overlay_pixel_fetch.sv | 132 +++++++++++++
 tb/tb_overlay_pixel_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Shared types and helpers for the LCD overlay fetch path.
// Pixels are RGBA words: R[31:24], G[23:16], B[15:8], A[7:0].
package overlay_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } rgba_t;

    localparam logic [31:0] TRANSPARENT_PIXEL = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } fetch_state_t;

    // Truncating product keeps the result in 8 bits: 255*255 -> 254.
    function automatic rgba_t scale_alpha(input rgba_t px, input logic [7:0] global_alpha);
        logic [15:0] prod;
        rgba_t       res;
        prod  = {8'd0, px.a} * {8'd0, global_alpha};
        res   = px;
        res.a = prod[15:8];
        return res;
    endfunction

endpackage

// File: rtl/overlay_fifo.sv
// Synchronous prefetch FIFO for overlay pixels; DEPTH must be a power of two.
// rd_data shows the head entry; the consumer registers it on the pop edge.
module overlay_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/overlay_pixel_fetch.sv
// Overlay pixel fetcher: prefetches RGBA words into a FIFO and serves one per de cycle.
// Optional build macro OVERLAY_GLOBAL_ALPHA_EN adds a global_alpha scaling input.
module overlay_pixel_fetch
    import overlay_pkg::*;
#(
    parameter int OVERLAY_WIDTH  = 360,
    parameter int OVERLAY_HEIGHT = 360,
    parameter int FIFO_DEPTH     = 16,
    parameter int ADDR_WIDTH     = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vsync,
    input  logic                  de,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_data_valid,
    input  logic [31:0]           mem_data,
`ifdef OVERLAY_GLOBAL_ALPHA_EN
    input  logic [7:0]            global_alpha,
`endif
    output logic [31:0]           foreground_pixel,
    output logic                  underflow
);

    localparam int TOTAL  = OVERLAY_WIDTH * OVERLAY_HEIGHT;
    localparam int PIX_W  = $clog2(TOTAL + 1);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int DISC_W = CW + 4;
    localparam logic [CW:0]           DEPTH_L   = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [PIX_W-1:0]      TOTAL_L   = PIX_W'(TOTAL);

    fetch_state_t          state, state_n;
    logic [CW-1:0]         outstanding, out_n;
    logic [DISC_W-1:0]     discard, disc_n;
    logic [PIX_W-1:0]      consumed, consumed_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [CW-1:0]         cnt_n;
    logic [31:0]           pix_n;
    logic [31:0]           head_px;
    logic                  rd_n, under_n;
    logic                  accept, ret_kept, ret_any, push, pop, starve, pix_left;
    logic [31:0]           fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;

    overlay_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (mem_data),
        .pop       (pop),
        .flush     (vsync),
        .rd_data   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef OVERLAY_GLOBAL_ALPHA_EN
    assign head_px = scale_alpha(rgba_t'(fifo_head), global_alpha);
`else
    assign head_px = fifo_head;
`endif

    always_comb begin
        accept   = mem_rd && mem_ready;
        // A return with nothing owed (e.g. left over from before reset) is simply ignored.
        ret_any  = mem_data_valid && (discard != '0 || outstanding != '0);
        ret_kept = mem_data_valid && discard == '0 && outstanding != '0;
        push     = ret_kept && !vsync && (!fifo_full || pop);
        pix_left = (consumed != TOTAL_L);
        pop      = de && !vsync && state != IDLE && pix_left && !fifo_empty;
        starve   = de && !vsync && state != IDLE && pix_left && fifo_empty;

        state_n    = state;
        addr_n     = mem_addr;
        out_n      = outstanding;
        disc_n     = discard;
        cnt_n      = fifo_count;
        consumed_n = consumed;
        under_n    = underflow | starve;
        pix_n      = pop ? head_px : TRANSPARENT_PIXEL;

        if (vsync) begin
            // Everything still owed to the old frame, including a request accepted
            // right now, becomes a return to drop.
            state_n    = FETCH;
            addr_n     = '0;
            out_n      = '0;
            disc_n     = discard + DISC_W'(outstanding) + DISC_W'(accept) - DISC_W'(ret_any);
            cnt_n      = '0;
            consumed_n = '0;
            under_n    = 1'b0;
        end else begin
            if (accept) addr_n = mem_addr + ADDR_WIDTH'(1);
            if (accept && state == FETCH && mem_addr == LAST_ADDR) state_n = DONE;
            if (mem_data_valid && discard != '0) disc_n = discard - DISC_W'(1);
            out_n = outstanding + CW'(accept) - CW'(ret_kept);
            cnt_n = fifo_count + CW'(push) - CW'(pop);
            if (pop || starve) consumed_n = consumed + PIX_W'(1);
        end

        // Registered request: look ahead at next-cycle occupancy so mem_rd never overcommits.
        rd_n = (state_n == FETCH) && (({1'b0, cnt_n} + {1'b0, out_n}) < DEPTH_L);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            mem_rd           <= 1'b0;
            mem_addr         <= '0;
            outstanding      <= '0;
            discard          <= '0;
            consumed         <= '0;
            foreground_pixel <= TRANSPARENT_PIXEL;
            underflow        <= 1'b0;
        end else begin
            state            <= state_n;
            mem_rd           <= rd_n;
            mem_addr         <= addr_n;
            outstanding      <= out_n;
            discard          <= disc_n;
            consumed         <= consumed_n;
            foreground_pixel <= pix_n;
            underflow        <= under_n;
        end
    end

endmodule

// File: tb/tb_overlay_pixel_fetch.sv
// Self-checking bench for overlay_pixel_fetch on a 4x2 overlay with an 8-entry FIFO.
// Expected pixels are queued when de is driven and compared one cycle later.
module tb_overlay_pixel_fetch;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 4;
    localparam int TOTAL = W * H;

    logic          clk;
    logic          reset_n;
    logic          vsync;
    logic          de;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic          mem_data_valid;
    logic [31:0]   mem_data;
    logic [31:0]   foreground_pixel;
    logic          underflow;
`ifdef OVERLAY_GLOBAL_ALPHA_EN
    logic [7:0]    global_alpha;
`endif

    overlay_pixel_fetch #(
        .OVERLAY_WIDTH  (W),
        .OVERLAY_HEIGHT (H),
        .FIFO_DEPTH     (DEPTH),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .vsync            (vsync),
        .de               (de),
        .mem_rd           (mem_rd),
        .mem_addr         (mem_addr),
        .mem_ready        (mem_ready),
        .mem_data_valid   (mem_data_valid),
        .mem_data         (mem_data),
`ifdef OVERLAY_GLOBAL_ALPHA_EN
        .global_alpha     (global_alpha),
`endif
        .foreground_pixel (foreground_pixel),
        .underflow        (underflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected blender pixel for a memory word (global_alpha fixed at 8'h80 = halve alpha).
    function automatic logic [31:0] exp_pix(input logic [31:0] w);
`ifdef OVERLAY_GLOBAL_ALPHA_EN
        return {w[31:8], 1'b0, w[7:1]};
`else
        return w;
`endif
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] mem_base = 32'h0;
    int          lat      = 3;
    int          cyc      = 0;
    int          acc_cnt  = 0;
    bit          rd_seen  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        mem_data_valid = 1'b0;
        mem_data       = 32'h0;
        forever begin
            @(negedge clk);
            mem_data_valid = 1'b0;
            mem_data       = 32'h0;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                mem_data_valid = 1'b1;
                mem_data       = ret_q[0].data;
                void'(ret_q.pop_front());
            end
            if (mem_rd) rd_seen = 1'b1;
            if (mem_rd && mem_ready) begin
                acc_cnt++;
                ret_q.push_back('{cyc + lat, mem_base + 32'(mem_addr)});
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    bit          de_last = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (de_last) begin
                if (exp_q.size() > 0) check("pixel", foreground_pixel, exp_q.pop_front());
                else                  check("sb_underrun", 32'(exp_q.size()), 32'd1);
            end
            de_last = de;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
    endtask

    task automatic drive_pix(input logic [31:0] exp);
        de = 1'b1;
        exp_q.push_back(exp);
        tick(1);
        de = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_fg"}, foreground_pixel, 32'h0);
        check({tag, "_underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n   = 1'b0;
        vsync     = 1'b0;
        de        = 1'b0;
        mem_ready = 1'b1;
`ifdef OVERLAY_GLOBAL_ALPHA_EN
        global_alpha = 8'h80;
`endif
        tick(3);
        check_reset_values("reset");

        // Idle after reset: no reads without a vsync.
        reset_n = 1'b1;
        rd_seen = 1'b0;
        tick(50);
        check("idle_no_rd", 32'(rd_seen), 32'd0);
        check("idle_fg", foreground_pixel, 32'h0);

        // Normal frame, 3-cycle latency, then 2 de cycles past the frame end.
        lat      = 3;
        mem_base = 32'h0;
        acc_cnt  = 0;
        pulse_vsync();
        tick(20);
        for (int i = 0; i < TOTAL; i++) drive_pix(exp_pix(32'(i)));
        check("frame_underflow", 32'(underflow), 32'd0);
        drive_pix(32'h0);
        drive_pix(32'h0);
        tick(2);
        check("past_end_underflow", 32'(underflow), 32'd0);
        check("frame_reads", 32'(acc_cnt), 32'(TOTAL));
        check("done_no_rd", 32'(mem_rd), 32'd0);

        // Slow memory: de starts 2 cycles after vsync, FIFO still empty.
        lat = 30;
        pulse_vsync();
        tick(1);
        for (int i = 0; i < 3; i++) drive_pix(32'h0);
        check("underflow_set", 32'(underflow), 32'd1);
        tick(40);
        check("underflow_sticky", 32'(underflow), 32'd1);
        for (int i = 0; i < TOTAL - 3; i++) drive_pix(exp_pix(32'(i)));
        drive_pix(32'h0);
        check("underflow_still", 32'(underflow), 32'd1);
        pulse_vsync();
        check("underflow_cleared", 32'(underflow), 32'd0);

        // vsync with 5 reads outstanding: their returns must be dropped.
        mem_ready = 1'b0;
        lat       = 10;
        tick(40);
        pulse_vsync();
        acc_cnt   = 0;
        mem_base  = 32'h100;
        mem_ready = 1'b1;
        for (int t = 0; t < 30 && acc_cnt < 5; t++) tick(1);
        mem_ready = 1'b0;
        check("stall_accepts", 32'(acc_cnt), 32'd5);
        tick(2);
        check("hold_rd", 32'(mem_rd), 32'd1);
        check("hold_addr", 32'(mem_addr), 32'd5);
        mem_base = 32'h0;
        pulse_vsync();
        acc_cnt   = 0;
        mem_ready = 1'b1;
        tick(40);
        for (int i = 0; i < TOTAL; i++) drive_pix(exp_pix(32'(i)));
        check("discard_underflow", 32'(underflow), 32'd0);
        check("discard_reads", 32'(acc_cnt), 32'(TOTAL));

        // Reset mid-frame with reads in flight, de while idle, then a fresh frame.
        lat      = 10;
        mem_base = 32'h200;
        pulse_vsync();
        tick(3);
        reset_n = 1'b0;
        tick(1);
        check_reset_values("midreset");
        reset_n = 1'b1;
        drive_pix(32'h0);
        drive_pix(32'h0);
        tick(20);
        check("idle_de_underflow", 32'(underflow), 32'd0);
        lat      = 3;
        mem_base = 32'h1122_33F8;
        acc_cnt  = 0;
        pulse_vsync();
        tick(20);
        for (int i = 0; i < TOTAL; i++) drive_pix(exp_pix(mem_base + 32'(i)));
        check("fresh_underflow", 32'(underflow), 32'd0);
        check("fresh_reads", 32'(acc_cnt), 32'(TOTAL));

        tick(3);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
